// File: rtl/pc_ras_unit.sv
// rtl/pc_ras_unit.sv - program counter with circular return-address stack
// Optional RAS_CHECK_EN: sticky overflow/underflow flags and a trap vector for RET on an empty stack.
module pc_ras_unit #(
  parameter int              PC_W        = 32,
  parameter int              OFFSET_W    = 26,
  parameter int              RAS_DEPTH   = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [PC_W-1:0] TRAP_VECTOR = PC_W'(32'hFFFF_FFF0),
  localparam int             CNT_W       = $clog2(RAS_DEPTH + 1),
  localparam int             PTR_W       = $clog2(RAS_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pc_write,
  input  logic [1:0]          pc_src,
  input  logic                call,
  input  logic [PC_W-1:0]     bta,
  input  logic [OFFSET_W-1:0] offset,
  output logic [PC_W-1:0]     pc,
  output logic [PC_W-1:0]     pc_next,
  output logic [PC_W-1:0]     ras_top,
  output logic [CNT_W-1:0]    ras_count,
  output logic                ras_full,
  output logic                ras_empty,
  output logic                ras_overflow,
  output logic                ras_underflow
);

  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_ras_top;
  logic [PC_W-1:0]  w_pc_next;
  logic [PTR_W-1:0] w_ptr_inc;
  logic [PTR_W-1:0] w_ptr_dec;

  always_comb begin
    w_full    = (r_count == CNT_W'(RAS_DEPTH));
    w_empty   = (r_count == '0);
    w_push    = pc_write && (pc_src == 2'b01) && call;
    w_pop     = pc_write && (pc_src == 2'b11) && !w_empty;
    w_pc_inc  = r_pc + PC_W'(1);
    w_ras_top = w_empty ? '0 : r_ras[r_ptr];
    // r_ptr addresses the newest entry; wrap explicitly so any depth works
    w_ptr_inc = (r_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
    w_ptr_dec = (r_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : r_ptr - PTR_W'(1);
  end

  always_comb begin
    w_pc_next = w_pc_inc;
    case (pc_src)
      2'b00: w_pc_next = w_pc_inc;
      2'b01: w_pc_next = {r_pc[PC_W-1:OFFSET_W], offset};
      2'b10: w_pc_next = bta;
      2'b11: begin
`ifdef RAS_CHECK_EN
        w_pc_next = w_empty ? TRAP_VECTOR : w_ras_top;
`else
        w_pc_next = w_ras_top;
`endif
      end
      default: w_pc_next = w_pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_ptr   <= '0;
      r_count <= '0;
    end else if (pc_write) begin
      r_pc <= w_pc_next;
      if (w_push) begin
        r_ptr <= w_ptr_inc;
        if (!w_full) r_count <= r_count + CNT_W'(1);
      end else if (w_pop) begin
        r_ptr   <= w_ptr_dec;
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Entry storage is left uncleared; r_count alone defines validity.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_ras[w_ptr_inc] <= w_pc_inc;
  end

`ifdef RAS_CHECK_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push && w_full) r_overflow <= 1'b1;
      if (pc_write && (pc_src == 2'b11) && w_empty) r_underflow <= 1'b1;
    end
  end

  assign ras_overflow  = r_overflow;
  assign ras_underflow = r_underflow;
`else
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

  assign pc        = r_pc;
  assign pc_next   = w_pc_next;
  assign ras_top   = w_ras_top;
  assign ras_count = r_count;
  assign ras_full  = w_full;
  assign ras_empty = w_empty;

endmodule

// File: doc/pc_ras_unit.md
PC_RAS_UNIT -- requirements
Module: pc_ras_unit

Interface
REQ-001 SHALL provide parameter PC_W, default 32, meaning program-counter width in bits.
REQ-002 SHALL provide parameter OFFSET_W, default 26, meaning jump-offset width; legal range 1..PC_W-1.
REQ-003 SHALL provide parameter RAS_DEPTH, default 8, meaning return-address-stack entries; legal range 2..64.
REQ-004 SHALL provide parameter RESET_PC, default 0, meaning PC value after reset.
REQ-005 SHALL provide parameter TRAP_VECTOR, default 32'hFFFF_FFF0 truncated to PC_W, meaning the RET-underflow target.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 pc_write  in  1  when high, the PC and RAS update this cycle.
REQ-009 pc_src  in  2  00 sequential, 01 jump, 10 branch taken, 11 return.
REQ-010 call  in  1  qualifies a jump (pc_src=01) as a call that pushes a return address.
REQ-011 bta  in  PC_W  branch target address.
REQ-012 offset  in  OFFSET_W  jump offset field.
REQ-013 pc  out  PC_W  current PC register.
REQ-014 pc_next  out  PC_W  combinational next-PC value.
REQ-015 ras_top  out  PC_W  top-of-stack entry; 0 when the stack is empty.
REQ-016 ras_count  out  clog2(RAS_DEPTH+1)  number of valid entries.
REQ-017 ras_full / ras_empty  out  1 each  ras_count==RAS_DEPTH / ras_count==0.
REQ-018 ras_overflow / ras_underflow  out  1 each  sticky error flags.

Function
REQ-019 pc_next SHALL be pc+1 for 00 (mod 2^PC_W), {pc[PC_W-1:OFFSET_W], offset} for 01, bta for 10, and ras_top for 11 on a non-empty stack.
REQ-020 pc SHALL load pc_next on a clk edge with pc_write=1; otherwise pc, the RAS and the flags SHALL hold.
REQ-021 pc_write=1, pc_src=01, call=1 SHALL push pc+1 onto the RAS in the same edge as the PC update.
REQ-022 call SHALL be ignored for any pc_src other than 01.
REQ-023 pc_write=1, pc_src=11 on a non-empty stack SHALL pop one entry; ras_count decrements by 1.
REQ-024 A push when full SHALL overwrite the oldest entry (circular); ras_count stays RAS_DEPTH and the newest entry becomes ras_top.
REQ-025 Successive pops after a wrap SHALL return entries newest-first; only the RAS_DEPTH most recent pushes are retained.
REQ-026 Latency: the PC and RAS update in one cycle; ras_top, ras_count, ras_full and ras_empty reflect the update in the cycle after the edge.

Reset
REQ-027 reset=1 at an edge SHALL set pc=RESET_PC, ras_count=0, ras_overflow=0 and ras_underflow=0, regardless of pc_write.
REQ-028 RAS entry storage need not be cleared; ras_top SHALL read 0 while ras_empty=1.
REQ-029 reset asserted during any operation SHALL take priority over that operation, and no push or pop SHALL occur.

Configuration
REQ-030 Macro RAS_CHECK_EN defined: a push when full SHALL set ras_overflow.
REQ-031 Macro RAS_CHECK_EN defined: a RET on an empty stack SHALL set pc_next=TRAP_VECTOR and set ras_underflow; both flags stay set until reset.
REQ-032 Macro RAS_CHECK_EN undefined: ras_overflow and ras_underflow SHALL be constant 0.
REQ-033 Macro RAS_CHECK_EN undefined: a RET on an empty stack SHALL load pc=0 and leave ras_count=0.

Verification
REQ-034 Reset then 3 cycles of pc_write=1, pc_src=00 -> pc=0,1,2,3; ras_empty=1.
REQ-035 pc=0x0400_0010, pc_src=01, call=1, offset=0x0000123 -> pc=0x0400_0123; ras_top=0x0400_0011; ras_count=1.
REQ-036 Then pc_src=11 -> pc=0x0400_0011; ras_count=0; ras_empty=1.
REQ-037 RAS_DEPTH=8: 9 calls from pc=1..9 (each call jumps back to pc+1) -> ras_full=1, ras_top=10, ras_overflow=1 (macro defined); 8 RETs return 10,9,...,3.
REQ-038 Empty stack, pc_src=11 -> macro defined: pc=TRAP_VECTOR, ras_underflow=1; macro undefined: pc=0, flags=0.
REQ-039 pc_write=0 with pc_src=01, call=1 -> pc and ras_count unchanged; reset asserted together with a push -> ras_count=0 and pc=RESET_PC.
